// File: rtl/mem_bank_cfg_loader.sv
// Memory-bank configuration region writer: assembles bit-line rows from a
// valid/ready word stream, drives each row onto bl and pulses its word line.
module mem_bank_cfg_loader #(
  parameter int BL_WIDTH = 514,
  parameter int WL_WIDTH = 407,
  parameter int DATA_W   = 32,
  parameter int BL_SETUP = 1,
  parameter int WL_PULSE = 2
) (
  input  logic                clk,
  input  logic                global_reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [0:BL_WIDTH-1] bl,
  output logic [0:WL_WIDTH-1] wl,
  output logic                busy,
  output logic                done
);

  localparam int NW = (BL_WIDTH + DATA_W - 1) / DATA_W;
  localparam int RW = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int SW = (BL_SETUP > 1) ? $clog2(BL_SETUP) : 1;
  localparam int PW = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  localparam logic [RW-1:0] LAST_ROW   = RW'(WL_WIDTH - 1);
  localparam logic [WW-1:0] LAST_WORD  = WW'(NW - 1);
  localparam logic [SW-1:0] LAST_SETUP = SW'(BL_SETUP - 1);
  localparam logic [PW-1:0] LAST_PULSE = PW'(WL_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [RW-1:0]       row_r;
  logic [WW-1:0]       word_r;
  logic [SW-1:0]       setup_r;
  logic [PW-1:0]       pulse_r;
  logic [BL_WIDTH-1:0] buf_r;
  logic [BL_WIDTH-1:0] buf_s;
  logic                xfer_s;

  logic                cfg_ready_r;
  logic                busy_r;
  logic                done_r;
  logic [0:BL_WIDTH-1] bl_r;
  logic [0:WL_WIDTH-1] wl_r;

  logic                cfg_ready_s;
  logic                busy_s;
  logic                done_s;
  logic                bl_on_s;
  logic                wl_on_s;
  logic [0:BL_WIDTH-1] bl_s;
  logic [0:WL_WIDTH-1] wl_s;

  assign xfer_s = cfg_valid & cfg_ready_r;

  // Stream word k lands on bit lines k*DATA_W .. k*DATA_W+DATA_W-1; bits past BL_WIDTH are dropped
  for (genvar j = 0; j < BL_WIDTH; j++) begin : g_buf
    localparam int K = j / DATA_W;
    localparam int I = j % DATA_W;
    assign buf_s[j] = (xfer_s && (word_r == WW'(K))) ? cfg_data[I] : buf_r[j];
    assign bl_s[j]  = bl_on_s & buf_s[j];
  end

  for (genvar r = 0; r < WL_WIDTH; r++) begin : g_wl
    assign wl_s[r] = wl_on_s & (row_r == RW'(r));
  end

  // State register, row/word/phase counters and row buffer
  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_r <= IDLE;
      row_r   <= '0;
      word_r  <= '0;
      setup_r <= '0;
      pulse_r <= '0;
      buf_r   <= '0;
    end else begin
      state_r <= state_s;
      buf_r   <= buf_s;

      if (xfer_s) begin
        word_r <= (word_r == LAST_WORD) ? '0 : word_r + WW'(1);
      end else begin
        word_r <= word_r;
      end

      if ((state_r == HOLD) && (row_r != LAST_ROW)) begin
        row_r <= row_r + RW'(1);
      end else if (((state_r == IDLE) || (state_r == DONE)) && start) begin
        row_r <= '0;
      end else begin
        row_r <= row_r;
      end

      setup_r <= ((state_r == SETUP) && (state_s == SETUP)) ? setup_r + SW'(1) : '0;
      pulse_r <= ((state_r == PULSE) && (state_s == PULSE)) ? pulse_r + PW'(1) : '0;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = LOAD;
        else       state_s = IDLE;
      end
      LOAD: begin
        if (xfer_s && (word_r == LAST_WORD)) state_s = SETUP;
        else                                 state_s = LOAD;
      end
      SETUP: begin
        if (setup_r == LAST_SETUP) state_s = PULSE;
        else                       state_s = SETUP;
      end
      PULSE: begin
        if (pulse_r == LAST_PULSE) state_s = HOLD;
        else                       state_s = PULSE;
      end
      HOLD: begin
        if (row_r == LAST_ROW) state_s = DONE;
        else                   state_s = LOAD;
      end
      DONE: begin
        if (start) state_s = DONE == DONE ? LOAD : DONE;
        else       state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track state_r
  always_comb begin
    cfg_ready_s = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    bl_on_s     = 1'b0;
    wl_on_s     = 1'b0;
    case (state_s)
      IDLE: begin
        busy_s = 1'b0;
      end
      LOAD: begin
        cfg_ready_s = 1'b1;
        busy_s      = 1'b1;
      end
      SETUP: begin
        busy_s  = 1'b1;
        bl_on_s = 1'b1;
      end
      PULSE: begin
        busy_s  = 1'b1;
        bl_on_s = 1'b1;
        wl_on_s = 1'b1;
      end
      HOLD: begin
        busy_s  = 1'b1;
        bl_on_s = 1'b1;
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (global_reset) begin
      cfg_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      bl_r        <= '0;
      wl_r        <= '0;
    end else begin
      cfg_ready_r <= cfg_ready_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      bl_r        <= bl_s;
      wl_r        <= wl_s;
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign bl        = bl_r;
  assign wl        = wl_r;

endmodule

// File: tb/tb_mem_bank_cfg_loader.sv
// Directed bench for mem_bank_cfg_loader with a 10-bit x 3-row region and 4-bit words.
module tb_mem_bank_cfg_loader;

  localparam int BLW = 10;
  localparam int WLW = 3;
  localparam int DW  = 4;

  logic           clk          = 1'b0;
  logic           global_reset = 1'b1;
  logic           start        = 1'b1;
  logic [DW-1:0]  cfg_data     = 4'hF;
  logic           cfg_valid    = 1'b1;
  logic           cfg_ready;
  logic [0:BLW-1] bl;
  logic [0:WLW-1] wl;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  mem_bank_cfg_loader #(
    .BL_WIDTH(BLW), .WL_WIDTH(WLW), .DATA_W(DW), .BL_SETUP(1), .WL_PULSE(2)
  ) dut (
    .clk(clk), .global_reset(global_reset), .start(start),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .bl(bl), .wl(wl), .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream words for three rows; expected bl values written with bl[0] leftmost
  logic [3:0] words  [9] = '{4'h5, 4'hA, 4'h3, 4'hF, 4'h0, 4'h2, 4'h1, 4'h8, 4'hE};
  logic [9:0] exp_bl [3] = '{10'b1010010111, 10'b1111000001, 10'b1000000101};
  logic [2:0] exp_wl [3] = '{3'b100, 3'b010, 3'b001};

  int         n_pulse = 0;
  int         plen    = 0;
  logic [9:0] pulse_bl [4];
  logic [2:0] pulse_wl [4];
  logic [0:BLW-1] prev_bl = '0;
  logic [0:WLW-1] prev_wl = '0;
  bit         mon_en      = 1'b0;
  logic       rst_at_edge = 1'b1;

  always @(posedge clk) rst_at_edge = global_reset;

  // Per-cycle invariants and word-line pulse recorder
  always @(negedge clk) begin
    if (mon_en) begin
      check_val("wl_onehot0", 32'($countones(wl) <= 1), 32'd1);
      check_val("ready_nonload", 32'(cfg_ready && !(busy && wl == '0 && bl == '0 && !done)), 32'd0);
      if (!rst_at_edge) begin
        if (wl != '0 || prev_wl != '0) check_val("bl_stable", bl, prev_bl);
        if (wl != '0 && prev_wl == '0) begin
          if (n_pulse < 4) begin
            pulse_bl[n_pulse] = bl;
            pulse_wl[n_pulse] = wl;
          end
          n_pulse++;
          plen = 1;
        end else if (wl != '0) begin
          check_val("wl_same", wl, prev_wl);
          plen++;
        end else if (prev_wl != '0) begin
          check_val("wl_len", plen, 32'd2);
        end
      end
      prev_bl = bl;
      prev_wl = wl;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous valid, 1: alternate valid, 2: start poke in row 1 pulse, 3: reset in row 1 pulse
  task automatic run_region(input int mode);
    int idx   = 0;
    int n     = 0;
    bit xfer  = 1'b0;
    bit poked = 1'b0;
    bit ph    = 1'b1;
    n_pulse = 0;
    for (int r = 0; r < 4; r++) begin
      pulse_bl[r] = '0;
      pulse_wl[r] = '0;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("start_ack", {done, busy, cfg_ready}, 32'b011);
    cfg_data  = words[0];
    cfg_valid = 1'b1;
    while (!done && n < 300) begin
      xfer = cfg_valid && cfg_ready;
      step();
      n++;
      start = 1'b0;
      if (xfer) idx++;
      ph = !ph;
      cfg_data  = words[(idx < 9) ? idx : 8];
      cfg_valid = (idx < 9) && (mode != 1 || ph);
      if (mode == 2 && wl[1] && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (mode == 3 && wl[1]) begin
        global_reset = 1'b1;
        cfg_valid    = 1'b0;
        step();
        global_reset = 1'b0;
        check_val("mid_rst_outs", {cfg_ready, busy, done, wl, bl}, 32'h0);
        return;
      end
    end
    cfg_valid = 1'b0;
    check_val("done_seen", done, 32'd1);
    if (mode != 1) check_val("done_lat", n, 32'd21);
    check_val("pulse_cnt", n_pulse, 32'd3);
    for (int r = 0; r < 3; r++) begin
      check_val("row_wl", pulse_wl[r], exp_wl[r]);
      check_val("row_bl", pulse_bl[r], exp_bl[r]);
    end
    step();
    step();
    check_val("done_hold", {done, busy, cfg_ready, wl, bl}, 32'h8000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held with start and valid asserted
    for (int c = 0; c < 3; c++) begin
      step();
      check_val("rst_outs", {cfg_ready, busy, done, wl, bl}, 32'h0);
    end
    global_reset = 1'b0;
    start        = 1'b0;
    cfg_valid    = 1'b0;
    mon_en       = 1'b1;
    step();
    check_val("idle_outs", {cfg_ready, busy, done, wl, bl}, 32'h0);
    step();
    check_val("idle_outs2", {cfg_ready, busy, done, wl, bl}, 32'h0);

    // Single row, cycle by cycle
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("t2_load", {cfg_ready, busy, done}, 32'b110);
    cfg_valid = 1'b1;
    cfg_data  = 4'h5;
    step();
    cfg_data  = 4'hA;
    step();
    cfg_data  = 4'h3;
    step();
    cfg_valid = 1'b0;
    check_val("t2_setup_bl", bl, 32'h297);
    check_val("t2_setup_wl", wl, 32'd0);
    check_val("t2_setup_rdy", cfg_ready, 32'd0);
    step();
    check_val("t2_pulse1_wl", wl, 32'b100);
    check_val("t2_pulse1_bl", bl, 32'h297);
    step();
    check_val("t2_pulse2_wl", wl, 32'b100);
    step();
    check_val("t2_hold_wl", wl, 32'd0);
    check_val("t2_hold_bl", bl, 32'h297);
    step();
    check_val("t2_next_load", {cfg_ready, busy, bl}, 32'b11_0000000000);
    global_reset = 1'b1;
    step();
    global_reset = 1'b0;
    check_val("t2_rst_outs", {cfg_ready, busy, done, wl, bl}, 32'h0);

    run_region(0);   // full region
    run_region(1);   // backpressure
    run_region(2);   // start ignored while busy
    run_region(0);   // start after done restarts at row 0
    run_region(3);   // reset during row 1 pulse
    run_region(0);   // reload begins at row 0

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
